fft_twiddle_cmul: RTL and testbench

- Pipelined complex multiplier for the FFT datapath: multiplies a butterfly output sample by a Q1.15 twiddle factor.
- Built on four instances of the team's 16x16 two's-complement Booth/Wallace multiplier (mul_tc_16_16).
- Adds operand/product/result registers, rounding, saturation and a valid/ready handshake.
- Sits between the butterfly and the next FFT stage's delay-commutator.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_round_sat.sv | 40 ++++
 rtl/mul_tc_16_16.sv | 14 +
 rtl/fft_twiddle_cmul.sv | 144 ++++++++++++++
 tb/tb_fft_twiddle_cmul.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the packed complex sample type.
`default_nettype none

package fft_pkg;

  localparam int DW        = 16;
  localparam int Q15_SHIFT = 15;
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

endpackage

`default_nettype wire

// File: rtl/fft_round_sat.sv
// Round-half-up, arithmetic right shift by SHIFT and clamp of a 33-bit sum to 16 bits.
`default_nettype none

module fft_round_sat
  import fft_pkg::*;
#(
  parameter int SHIFT = Q15_SHIFT
) (
  input  logic [32:0] i_sum,
  output logic [15:0] o_res,
  output logic        o_sat
);

  localparam logic signed [32:0] c_rnd   = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] c_max   = 33'(SAT_MAX);
  localparam logic signed [32:0] c_min   = 33'(SAT_MIN);
  localparam logic        [15:0] c_max16 = 16'(SAT_MAX);
  localparam logic        [15:0] c_min16 = 16'(SAT_MIN);

  logic signed [32:0] w_rnd;
  logic signed [32:0] w_shr;

  assign w_rnd = $signed(i_sum) + c_rnd;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_res = w_shr[15:0];
    o_sat = 1'b0;
    if (w_shr > c_max) begin
      o_res = c_max16;
      o_sat = 1'b1;
    end else if (w_shr < c_min) begin
      o_res = c_min16;
      o_sat = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_tc_16_16.sv
// 16x16 two's-complement multiplier (Booth/Wallace macro), combinational, full 32-bit product.
`default_nettype none

module mul_tc_16_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  assign o_p = $signed(i_a) * $signed(i_b);

endmodule

`default_nettype wire

// File: rtl/fft_twiddle_cmul.sv
// 3-stage complex multiplier x*w with Q1.15 rounding/saturation and a global-stall handshake.
// Optional FFT_TWIDDLE_CONJ_EN adds a per-beat 'conj' input that multiplies by conj(w) instead.
`default_nettype none

module fft_twiddle_cmul #(
  parameter int DW    = 16,
  parameter int SHIFT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] x_re,
  input  logic [DW-1:0] x_im,
  input  logic [DW-1:0] w_re,
  input  logic [DW-1:0] w_im,
`ifdef FFT_TWIDDLE_CONJ_EN
  input  logic          conj,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          sat_flag
);

  import fft_pkg::*;

  if (DW != fft_pkg::DW) begin : g_dw_check
    $error("fft_twiddle_cmul: DW must be 16 to match mul_tc_16_16");
  end

  logic    w_stall;
  logic    w_adv;
  logic    w_conj_in;

  logic    r1_v, r1_last, r1_conj;
  cplx16_t r1_x, r1_w;

  logic        r2_v, r2_last, r2_conj;
  logic [31:0] r2_rr, r2_ii, r2_ri, r2_ir;
  logic [31:0] w_rr, w_ii, w_ri, w_ir;

  logic [32:0] w_re_sum, w_im_sum;
  logic [15:0] w_re_rs, w_im_rs;
  logic        w_re_sat, w_im_sat;

  logic        r3_v, r3_last, r3_sat;
  logic [15:0] r3_re, r3_im;

`ifdef FFT_TWIDDLE_CONJ_EN
  assign w_conj_in = conj;
`else
  assign w_conj_in = 1'b0;
`endif

  // Whole pipeline freezes only when the output beat is held back; in_ready follows out_ready combinationally.
  assign w_stall  = r3_v & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_v    <= 1'b0;
      r1_last <= 1'b0;
      r1_conj <= 1'b0;
      r1_x    <= '0;
      r1_w    <= '0;
    end else if (w_adv) begin
      r1_v <= in_valid;
      if (in_valid) begin
        r1_last <= in_last;
        r1_conj <= w_conj_in;
        r1_x    <= '{re: x_re, im: x_im};
        r1_w    <= '{re: w_re, im: w_im};
      end
    end
  end

  mul_tc_16_16 u_mul_rr (.i_a(r1_x.re), .i_b(r1_w.re), .o_p(w_rr));
  mul_tc_16_16 u_mul_ii (.i_a(r1_x.im), .i_b(r1_w.im), .o_p(w_ii));
  mul_tc_16_16 u_mul_ri (.i_a(r1_x.re), .i_b(r1_w.im), .o_p(w_ri));
  mul_tc_16_16 u_mul_ir (.i_a(r1_x.im), .i_b(r1_w.re), .o_p(w_ir));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_v    <= 1'b0;
      r2_last <= 1'b0;
      r2_conj <= 1'b0;
      r2_rr   <= '0;
      r2_ii   <= '0;
      r2_ri   <= '0;
      r2_ir   <= '0;
    end else if (w_adv) begin
      r2_v    <= r1_v;
      r2_last <= r1_last;
      r2_conj <= r1_conj;
      r2_rr   <= w_rr;
      r2_ii   <= w_ii;
      r2_ri   <= w_ri;
      r2_ir   <= w_ir;
    end
  end

  // Conjugation swaps add/sub rather than negating w_im, so w_im = -32768 stays exact.
  always_comb begin
    w_re_sum = {r2_rr[31], r2_rr} - {r2_ii[31], r2_ii};
    w_im_sum = {r2_ri[31], r2_ri} + {r2_ir[31], r2_ir};
    if (r2_conj) begin
      w_re_sum = {r2_rr[31], r2_rr} + {r2_ii[31], r2_ii};
      w_im_sum = {r2_ir[31], r2_ir} - {r2_ri[31], r2_ri};
    end
  end

  fft_round_sat #(.SHIFT(SHIFT)) u_rs_re (.i_sum(w_re_sum), .o_res(w_re_rs), .o_sat(w_re_sat));
  fft_round_sat #(.SHIFT(SHIFT)) u_rs_im (.i_sum(w_im_sum), .o_res(w_im_rs), .o_sat(w_im_sat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_v    <= 1'b0;
      r3_last <= 1'b0;
      r3_sat  <= 1'b0;
      r3_re   <= '0;
      r3_im   <= '0;
    end else if (w_adv) begin
      r3_v    <= r2_v;
      r3_last <= r2_v & r2_last;
      r3_sat  <= r2_v & (w_re_sat | w_im_sat);
      r3_re   <= w_re_rs;
      r3_im   <= w_im_rs;
    end
  end

  assign out_valid = r3_v;
  assign out_last  = r3_last;
  assign sat_flag  = r3_sat;
  assign out_re    = r3_re;
  assign out_im    = r3_im;

endmodule

`default_nettype wire

// File: tb/tb_fft_twiddle_cmul.sv
// Scoreboard bench for fft_twiddle_cmul: directed cases, random stream, stall and async reset.
`default_nettype none

module tb_fft_twiddle_cmul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [15:0] x_re = '0, x_im = '0, w_re = '0, w_im = '0;
  logic        conj_s = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_re, out_im;
  logic        out_last;
  logic        sat_flag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               sat;
    logic               last;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  fft_twiddle_cmul dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .x_re     (x_re),
    .x_im     (x_im),
    .w_re     (w_re),
    .w_im     (w_im),
`ifdef FFT_TWIDDLE_CONJ_EN
    .conj     (conj_s),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last),
    .sat_flag (sat_flag)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] sat16(input longint v, output logic s);
    s = 1'b0;
    if (v > 32767) begin s = 1'b1; return 16'sd32767; end
    if (v < -32768) begin s = 1'b1; return -16'sd32768; end
    return 16'(v);
  endfunction

  function automatic exp_t model(input logic [15:0] xr, xi, wr, wi, input logic l, input logic cj);
    longint rr, ii, ri, ir, sr, si;
    logic   s1, s2;
    exp_t   m;
    rr = longint'($signed(xr)) * longint'($signed(wr));
    ii = longint'($signed(xi)) * longint'($signed(wi));
    ri = longint'($signed(xr)) * longint'($signed(wi));
    ir = longint'($signed(xi)) * longint'($signed(wr));
    sr = cj ? rr + ii : rr - ii;
    si = cj ? ir - ri : ri + ir;
    m.re   = sat16((sr + 16384) >>> 15, s1);
    m.im   = sat16((si + 16384) >>> 15, s2);
    m.sat  = s1 | s2;
    m.last = l;
    return m;
  endfunction

  // Output transfers are popped and input transfers pushed, both judged before the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("sb_re",   $signed(out_re), e_mon.re);
          chk("sb_im",   $signed(out_im), e_mon.im);
          chk("sb_sat",  sat_flag, e_mon.sat);
          chk("sb_last", out_last, e_mon.last);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(x_re, x_im, w_re, w_im, in_last, conj_s));
    end
  end

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_single(input logic [15:0] xr, xi, wr, wi, input logic cj,
                            output logic signed [15:0] ore, oim, output logic osat, output int lat);
    @(posedge clk); #1;
    x_re = xr; x_im = xi; w_re = wr; w_im = wi; conj_s = cj;
    in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; ore = '0; oim = '0; osat = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = k; ore = $signed(out_re); oim = $signed(out_im); osat = sat_flag;
        break;
      end
    end
  endtask

  task automatic push_beat(input logic [15:0] xr, xi, wr, wi, input logic l, input logic cj);
    logic acc;
    int   n;
    x_re = xr; x_im = xi; w_re = wr; w_im = wi; in_last = l; conj_s = cj;
    in_valid = 1'b1;
    n = 0;
    forever begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin chk("push_timeout", 0, 1); break; end
    end
  endtask

  initial begin
    logic signed [15:0] r_re, r_im;
    logic               r_sat, cj;
    int                 lat, n_acc;
    logic [15:0]        held;
    logic               held_set;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_sat_flag",  sat_flag, 0);
    chk("rst_out_re",    $signed(out_re), 0);
    chk("rst_out_im",    $signed(out_im), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_single(16'd16384, 16'd0, 16'd32767, 16'd0, 1'b0, r_re, r_im, r_sat, lat);
    chk("unit_lat", lat, 3);
    chk("unit_re", r_re, 16384);
    chk("unit_im", r_im, 0);
    chk("unit_sat", r_sat, 0);
    drain();

    run_single(16'd1000, 16'd2000, 16'd0, 16'd32767, 1'b0, r_re, r_im, r_sat, lat);
    chk("j_re", r_re, -2000);
    chk("j_im", r_im, 1000);
    drain();

`ifdef FFT_TWIDDLE_CONJ_EN
    run_single(16'd1000, 16'd2000, 16'd0, 16'd32767, 1'b1, r_re, r_im, r_sat, lat);
    chk("conj_re", r_re, 2000);
    chk("conj_im", r_im, -1000);
    drain();
`endif

    run_single(16'h8000, 16'd0, 16'h8000, 16'd0, 1'b0, r_re, r_im, r_sat, lat);
    chk("minsq_re", r_re, 32767);
    chk("minsq_im", r_im, 0);
    chk("minsq_sat", r_sat, 1);
    drain();

    // re: 2^30 + 32768*32767 clamps; im: -32768*32767 + 2^30 = 32768 -> rounds to 1.
    run_single(16'h8000, 16'h8000, 16'h8000, 16'd32767, 1'b0, r_re, r_im, r_sat, lat);
    chk("corner_re", r_re, 32767);
    chk("corner_im", r_im, 1);
    chk("corner_sat", r_sat, 1);
    drain();

    for (int i = 1; i <= 64; i++) begin
`ifdef FFT_TWIDDLE_CONJ_EN
      cj = 1'($urandom_range(0, 1));
`else
      cj = 1'b0;
`endif
      push_beat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), (i == 64), cj);
    end
    in_last = 1'b0;
    drain();
    chk("stream_sb_empty", sb.size(), 0);

    n_acc = 0; held = '0; held_set = 1'b0;
    conj_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      x_re = 16'($urandom); x_im = 16'($urandom); w_re = 16'($urandom); w_im = 16'($urandom);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      if (out_valid) begin
        if (!held_set) begin held = out_re; held_set = 1'b1; end
        else chk("stall_stable_re", $signed(out_re), $signed(held));
      end
      @(posedge clk); #1;
    end
    chk("stall_accepts", n_acc, 3);
    chk("stall_in_ready", in_ready, 0);
    drain();

    for (int c = 0; c < 3; c++) begin
      x_re = 16'($urandom); x_im = 16'($urandom); w_re = 16'($urandom); w_im = 16'($urandom);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_re", $signed(out_re), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_idle", out_valid, 0);
    end
    run_single(16'd300, 16'hFF00, 16'd20000, 16'd12345, 1'b0, r_re, r_im, r_sat, lat);
    chk("post_rst_lat", lat, 3);
    drain();
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
